// File: rtl/sprite_unit.sv
// sprite_unit: one slice of the sprite chain. Holds a double-buffered sprite
// position/base, tests each scanned pixel against the sprite box, fetches the
// sprite byte and merges it into the daisy-chained pixel stream.
// Pipeline: edge N registers mem_address, edge N+1 registers membus,
// edge N+2 presents rgbout/enable_out/screenXout/screenYout.
// Optional build macro: SPRITE_TRANSPARENCY_EN (pixels equal to TRANSPARENT
// are not drawn and let the upstream colour through).
module sprite_unit #(
  parameter logic [5:0]  SPRITE_ID   = 6'd0,
  parameter int unsigned SPRITE_W    = 8,
  parameter int unsigned SPRITE_H    = 8,
  parameter logic [7:0]  TRANSPARENT = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  screenX,
  input  logic [7:0]  screenY,
  input  logic [7:0]  rgbin,
  input  logic        prev_enable,
  input  logic        program_active,
  input  logic [5:0]  requested_sprite_id,
  input  logic [7:0]  setx,
  input  logic [7:0]  sety,
  input  logic [15:0] set_address,
  input  logic        clear,
  input  logic [7:0]  membus,
  output logic [15:0] mem_address,
  output logic [7:0]  rgbout,
  output logic        enable_out,
  output logic [7:0]  screenXout,
  output logic [7:0]  screenYout
);

  localparam int unsigned PW = 8;
  localparam int unsigned AW = 16;
  localparam int unsigned EW = PW + 1;

  // State encoding is {visible, pending}
  typedef enum logic [1:0] {
    S_HIDDEN        = 2'b00,
    S_ARMED         = 2'b01,
    S_SHOWN         = 2'b10,
    S_SHOWN_PENDING = 2'b11
  } state_e;

  state_e state_q, state_d;

  logic frame_start_c;
  logic write_c;
  logic visible_c;
  logic pending_c;
  logic load_shadow_c;
  logic commit_shadow_c;
  logic commit_direct_c;

  // Active and shadow register sets
  logic [PW-1:0] posx_q, posx_d;
  logic [PW-1:0] posy_q, posy_d;
  logic [AW-1:0] base_q, base_d;
  logic [PW-1:0] sh_x_q, sh_x_d;
  logic [PW-1:0] sh_y_q, sh_y_d;
  logic [AW-1:0] sh_base_q, sh_base_d;

  // Stage 0 combinational results
  logic          hit_c;
  logic          hit_x_c;
  logic          hit_y_c;
  logic [PW-1:0] dx_c;
  logic [PW-1:0] dy_c;
  logic [AW-1:0] addr_c;

  // Stage 1 registers (after edge N)
  logic [AW-1:0] mem_address_q;
  logic          hit1_q;
  logic [PW-1:0] rgb1_q;
  logic          prev1_q;
  logic [PW-1:0] x1_q;
  logic [PW-1:0] y1_q;

  // Stage 2 registers (after edge N+1)
  logic [PW-1:0] membus_q;
  logic          hit2_q;
  logic [PW-1:0] rgb2_q;
  logic          prev2_q;
  logic [PW-1:0] x2_q;
  logic [PW-1:0] y2_q;

  // Output stage registers (after edge N+2)
  logic [PW-1:0] rgbout_q, rgbout_d;
  logic          enable_q, enable_d;
  logic [PW-1:0] xout_q;
  logic [PW-1:0] yout_q;

  logic drawn_c;

  assign frame_start_c = (screenX == 8'd0) && (screenY == 8'd0);
  assign write_c       = program_active && (requested_sprite_id == SPRITE_ID);

  // Programming state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_HIDDEN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear overrides every transition
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_HIDDEN;
    end else begin
      case (state_q)
        S_HIDDEN: begin
          if (write_c) begin
            state_d = frame_start_c ? S_SHOWN : S_ARMED;
          end
        end
        S_ARMED: begin
          if (frame_start_c) begin
            state_d = S_SHOWN;
          end
        end
        S_SHOWN: begin
          if (write_c && !frame_start_c) begin
            state_d = S_SHOWN_PENDING;
          end
        end
        S_SHOWN_PENDING: begin
          if (frame_start_c) begin
            state_d = S_SHOWN;
          end
        end
        default: state_d = S_HIDDEN;
      endcase
    end
  end

  // State decode into register-set control strobes
  always_comb begin
    visible_c       = state_q[1];
    pending_c       = state_q[0];
    load_shadow_c   = 1'b0;
    commit_shadow_c = 1'b0;
    commit_direct_c = 1'b0;
    if (!clear) begin
      if (write_c && frame_start_c) begin
        commit_direct_c = 1'b1;
      end else if (write_c) begin
        load_shadow_c = 1'b1;
      end else if (frame_start_c && pending_c) begin
        commit_shadow_c = 1'b1;
      end
    end
  end

  // Next values for the active and shadow sets
  always_comb begin
    posx_d    = posx_q;
    posy_d    = posy_q;
    base_d    = base_q;
    sh_x_d    = sh_x_q;
    sh_y_d    = sh_y_q;
    sh_base_d = sh_base_q;
    if (load_shadow_c) begin
      sh_x_d    = setx;
      sh_y_d    = sety;
      sh_base_d = set_address;
    end
    if (commit_direct_c) begin
      posx_d = setx;
      posy_d = sety;
      base_d = set_address;
    end else if (commit_shadow_c) begin
      posx_d = sh_x_q;
      posy_d = sh_y_q;
      base_d = sh_base_q;
    end
  end

  // Active/shadow set registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      posx_q    <= '0;
      posy_q    <= '0;
      base_q    <= '0;
      sh_x_q    <= '0;
      sh_y_q    <= '0;
      sh_base_q <= '0;
    end else begin
      posx_q    <= posx_d;
      posy_q    <= posy_d;
      base_q    <= base_d;
      sh_x_q    <= sh_x_d;
      sh_y_q    <= sh_y_d;
      sh_base_q <= sh_base_d;
    end
  end

  // Stage 0: box test at 9 bits (clips at 255) and sprite-memory address
  always_comb begin
    hit_x_c = ({1'b0, screenX} >= {1'b0, posx_q}) &&
              ({1'b0, screenX} < ({1'b0, posx_q} + EW'(SPRITE_W)));
    hit_y_c = ({1'b0, screenY} >= {1'b0, posy_q}) &&
              ({1'b0, screenY} < ({1'b0, posy_q} + EW'(SPRITE_H)));
    hit_c   = visible_c && hit_x_c && hit_y_c;
    dx_c    = screenX - posx_q;
    dy_c    = screenY - posy_q;
    addr_c  = base_q + (AW'(dy_c) * AW'(SPRITE_W)) + AW'(dx_c);
  end

  // Stage 1: register address and align pass-through signals
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_address_q <= '0;
      hit1_q        <= 1'b0;
      rgb1_q        <= '0;
      prev1_q       <= 1'b0;
      x1_q          <= '0;
      y1_q          <= '0;
    end else begin
      mem_address_q <= hit_c ? addr_c : '0;
      hit1_q        <= hit_c;
      rgb1_q        <= rgbin;
      prev1_q       <= prev_enable;
      x1_q          <= screenX;
      y1_q          <= screenY;
    end
  end

  // Stage 2: capture the memory byte returned for the stage-1 address
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      membus_q <= '0;
      hit2_q   <= 1'b0;
      rgb2_q   <= '0;
      prev2_q  <= 1'b0;
      x2_q     <= '0;
      y2_q     <= '0;
    end else begin
      membus_q <= membus;
      hit2_q   <= hit1_q;
      rgb2_q   <= rgb1_q;
      prev2_q  <= prev1_q;
      x2_q     <= x1_q;
      y2_q     <= y1_q;
    end
  end

`ifdef SPRITE_TRANSPARENCY_EN
  assign drawn_c = (membus_q != TRANSPARENT);
`else
  assign drawn_c = 1'b1;
  wire unused_transparent = &{1'b0, TRANSPARENT};
`endif

  // Merge: upstream wins, then a drawn hit, else pass the stream through
  always_comb begin
    rgbout_d = rgb2_q;
    enable_d = prev2_q;
    if (!prev2_q && hit2_q && drawn_c) begin
      rgbout_d = membus_q;
      enable_d = 1'b1;
    end
  end

  // Output stage registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgbout_q <= '0;
      enable_q <= 1'b0;
      xout_q   <= '0;
      yout_q   <= '0;
    end else begin
      rgbout_q <= rgbout_d;
      enable_q <= enable_d;
      xout_q   <= x2_q;
      yout_q   <= y2_q;
    end
  end

  assign mem_address = mem_address_q;
  assign rgbout      = rgbout_q;
  assign enable_out  = enable_q;
  assign screenXout  = xout_q;
  assign screenYout  = yout_q;

endmodule

// File: tb/tb_sprite_unit.sv
// Testbench for sprite_unit: directed vector tables, hand sequences for the
// multi-cycle corners, then randomized traffic against a pixel-history model.
module tb_sprite_unit;

  localparam int WI = 8;
  localparam int HI = 8;
  localparam int N  = 8192;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  screenX, screenY, rgbin, setx, sety, membus;
  logic        prev_enable, program_active, clear;
  logic [5:0]  requested_sprite_id;
  logic [15:0] set_address;
  logic [15:0] mem_address;
  logic [7:0]  rgbout, screenXout, screenYout;
  logic        enable_out;

  int checks = 0;
  int errors = 0;
  int cyc = 2;

  // Model: sprite registers as the rules describe them
  bit          m_vis, m_pend;
  logic [7:0]  m_px, m_py, m_sx, m_sy;
  logic [15:0] m_pb, m_sb;

  // Per-pixel history indexed by edge number
  logic [7:0]  h_x[N], h_y[N], h_rgb[N], h_mb[N];
  bit          h_prev[N], h_hit[N];

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] addr;
  } vec_t;

  vec_t tab1[8];
  vec_t tab2[6];

  sprite_unit dut (
    .clk(clk), .rst_n(rst_n), .screenX(screenX), .screenY(screenY),
    .rgbin(rgbin), .prev_enable(prev_enable), .program_active(program_active),
    .requested_sprite_id(requested_sprite_id), .setx(setx), .sety(sety),
    .set_address(set_address), .clear(clear), .membus(membus),
    .mem_address(mem_address), .rgbout(rgbout), .enable_out(enable_out),
    .screenXout(screenXout), .screenYout(screenYout)
  );

  always #5 clk = ~clk;

  function automatic bit drawn(input logic [7:0] mb);
`ifdef SPRITE_TRANSPARENCY_EN
    return mb != 8'h00;
`else
    return 1'b1;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Plain scan pixel with no programming activity
  task automatic idle(input logic [7:0] x, input logic [7:0] y);
    screenX = x;
    screenY = y;
    rgbin = 8'($urandom);
    prev_enable = 1'b0;
    program_active = 1'b0;
    requested_sprite_id = 6'd0;
    setx = 8'd0;
    sety = 8'd0;
    set_address = 16'd0;
    clear = 1'b0;
    membus = 8'($urandom);
  endtask

  task automatic prog(input logic [5:0] id, input logic [7:0] x, input logic [7:0] y,
                      input logic [15:0] a);
    program_active = 1'b1;
    requested_sprite_id = id;
    setx = x;
    sety = y;
    set_address = a;
  endtask

  // One pixel clock: predict, clock, compare every output
  task automatic tick();
    int k;
    bit hit, p, hh, d;
    logic [15:0] a;
    logic [7:0] e_rgb, e_x, e_y;
    bit e_en;
    k = cyc;
    a = 16'd0;
    e_rgb = 8'd0; e_en = 1'b0; e_x = 8'd0; e_y = 8'd0;
    if (!rst_n) begin
      m_vis = 0; m_pend = 0;
      m_px = 0; m_py = 0; m_pb = 0; m_sx = 0; m_sy = 0; m_sb = 0;
      for (int j = k - 1; j <= k; j++) begin
        h_x[j] = 0; h_y[j] = 0; h_rgb[j] = 0; h_mb[j] = 0; h_prev[j] = 0; h_hit[j] = 0;
      end
    end else begin
      hit = m_vis && int'(screenX) >= int'(m_px) && int'(screenX) < int'(m_px) + WI &&
            int'(screenY) >= int'(m_py) && int'(screenY) < int'(m_py) + HI;
      if (hit)
        a = 16'(int'(m_pb) + (int'(screenY) - int'(m_py)) * WI + int'(screenX) - int'(m_px));
      h_x[k] = screenX; h_y[k] = screenY; h_rgb[k] = rgbin; h_mb[k] = membus;
      h_prev[k] = prev_enable; h_hit[k] = hit;
      p = h_prev[k-2]; hh = h_hit[k-2]; d = drawn(h_mb[k-1]);
      e_rgb = (!p && hh && d) ? h_mb[k-1] : h_rgb[k-2];
      e_en = p || (hh && d);
      e_x = h_x[k-2];
      e_y = h_y[k-2];
      if (clear) begin
        m_vis = 0; m_pend = 0;
      end else if (program_active && requested_sprite_id == 6'd0) begin
        if (screenX == 0 && screenY == 0) begin
          m_px = setx; m_py = sety; m_pb = set_address; m_vis = 1; m_pend = 0;
        end else begin
          m_sx = setx; m_sy = sety; m_sb = set_address; m_pend = 1;
        end
      end else if (screenX == 0 && screenY == 0 && m_pend) begin
        m_px = m_sx; m_py = m_sy; m_pb = m_sb; m_vis = 1; m_pend = 0;
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (mem_address !== a || rgbout !== e_rgb || enable_out !== e_en ||
        screenXout !== e_x || screenYout !== e_y) begin
      errors++;
      $display("FAIL pipe cyc=%0d: got addr=%h rgb=%h en=%b x=%h y=%h want addr=%h rgb=%h en=%b x=%h y=%h",
               k, mem_address, rgbout, enable_out, screenXout, screenYout,
               a, e_rgb, e_en, e_x, e_y);
    end
    cyc++;
  endtask

  function automatic logic [7:0] pick();
    return ($urandom_range(0, 3) == 0) ? 8'($urandom_range(232, 255)) : 8'($urandom_range(0, 47));
  endfunction

  initial begin
    tab1[0] = '{8'd100, 8'd50, 16'd64};
    tab1[1] = '{8'd103, 8'd52, 16'd83};
    tab1[2] = '{8'd107, 8'd57, 16'd127};
    tab1[3] = '{8'd104, 8'd55, 16'd108};
    tab1[4] = '{8'd108, 8'd50, 16'd0};
    tab1[5] = '{8'd99,  8'd50, 16'd0};
    tab1[6] = '{8'd100, 8'd58, 16'd0};
    tab1[7] = '{8'd100, 8'd49, 16'd0};
    tab2[0] = '{8'd252, 8'd10, 16'd1000};
    tab2[1] = '{8'd255, 8'd10, 16'd1003};
    tab2[2] = '{8'd255, 8'd17, 16'd1059};
    tab2[3] = '{8'd0,   8'd10, 16'd0};
    tab2[4] = '{8'd3,   8'd10, 16'd0};
    tab2[5] = '{8'd251, 8'd10, 16'd0};

    // Reset with garbage on the inputs; outputs must be zero
    idle(8'd0, 8'd0);
    prog(6'd0, 8'd1, 8'd1, 16'd9);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Scan with no writes: stream passes through, no addresses
    for (int i = 0; i < 300; i++) begin
      idle(8'(i), 8'(i / 7));
      tick();
    end

    // Non-matching ID is ignored
    idle(8'd9, 8'd9);
    prog(6'd5, 8'd0, 8'd0, 16'd77);
    tick();
    idle(8'd0, 8'd0); tick();
    idle(8'd1, 8'd1); tick();
    check("foreign_id_ignored", 64'(mem_address), 64'd0);

    // Program sprite at (100,50) base 64, commit on frame start
    idle(8'd5, 8'd5);
    prog(6'd0, 8'd100, 8'd50, 16'd64);
    tick();
    idle(8'd100, 8'd50); tick();
    check("armed_not_drawn", 64'(mem_address), 64'd0);
    idle(8'd0, 8'd0); tick();
    foreach (tab1[i]) begin
      idle(tab1[i].x, tab1[i].y);
      tick();
      check($sformatf("tab1[%0d]", i), 64'(mem_address), 64'(tab1[i].addr));
    end

    // Mid-frame rewrite takes effect only at the next frame start
    idle(8'd60, 8'd60);
    prog(6'd0, 8'd200, 8'd100, 16'd128);
    tick();
    idle(8'd100, 8'd50); tick();
    check("old_pos_same_frame", 64'(mem_address), 64'd64);
    idle(8'd200, 8'd100); tick();
    check("new_pos_same_frame", 64'(mem_address), 64'd0);
    idle(8'd0, 8'd0); tick();
    idle(8'd100, 8'd50); tick();
    check("old_pos_next_frame", 64'(mem_address), 64'd0);
    idle(8'd200, 8'd100); tick();
    check("new_pos_next_frame", 64'(mem_address), 64'd128);

    // Right-edge clipping at column 255
    idle(8'd9, 8'd9);
    prog(6'd0, 8'd252, 8'd10, 16'd1000);
    tick();
    idle(8'd0, 8'd0); tick();
    foreach (tab2[i]) begin
      idle(tab2[i].x, tab2[i].y);
      tick();
      check($sformatf("tab2[%0d]", i), 64'(mem_address), 64'(tab2[i].addr));
    end

    // Upstream already drew the pixel
    idle(8'd252, 8'd10);
    prev_enable = 1'b1;
    rgbin = 8'h33;
    tick();
    idle(8'd0, 8'd20); membus = 8'hAA; tick();
    idle(8'd0, 8'd20); tick();
    check("upstream_wins_rgb", 64'(rgbout), 64'h33);
    check("upstream_wins_en", 64'(enable_out), 64'd1);

    // Hit with a colour-key byte
    idle(8'd253, 8'd10);
    rgbin = 8'h44;
    tick();
    idle(8'd0, 8'd20); membus = 8'h00; tick();
    idle(8'd0, 8'd20); tick();
`ifdef SPRITE_TRANSPARENCY_EN
    check("key_rgb", 64'(rgbout), 64'h44);
    check("key_en", 64'(enable_out), 64'd0);
`else
    check("key_rgb", 64'(rgbout), 64'h00);
    check("key_en", 64'(enable_out), 64'd1);
`endif

    // Clear together with a write hides the sprite and drops the write
    idle(8'd5, 8'd5);
    prog(6'd0, 8'd20, 8'd20, 16'd300);
    clear = 1'b1;
    tick();
    idle(8'd0, 8'd0); tick();
    idle(8'd20, 8'd20); tick();
    check("clear_drops_write", 64'(mem_address), 64'd0);
    idle(8'd252, 8'd10); tick();
    check("clear_hides_old", 64'(mem_address), 64'd0);

    // Write on the frame-start pixel commits directly
    idle(8'd0, 8'd0);
    prog(6'd0, 8'd30, 8'd40, 16'd500);
    tick();
    idle(8'd30, 8'd40); tick();
    check("bypass_first", 64'(mem_address), 64'd500);
    idle(8'd31, 8'd41); tick();
    check("bypass_offset", 64'(mem_address), 64'd509);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) idle(8'd0, 8'd0);
      else idle(pick(), pick());
      if ($urandom_range(0, 7) == 0)
        prog(6'($urandom_range(0, 1)), pick(), pick(), 16'($urandom));
      clear = ($urandom_range(0, 63) == 0);
      prev_enable = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) membus = 8'h00;
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
      rst_n = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
